// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD framebuffer writer.
// Word index arithmetic lives here so every user agrees on the layout.
package lcd_pkg;

    localparam logic [7:0] LCD_W             = 8'd160;
    localparam logic [7:0] LCD_H             = 8'd144;
    localparam logic [4:0] FB_WORDS_PER_LINE = 5'd20;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } fb_word_t;

    // y*20 + word column, built from shifts; the largest result is 2879
    function automatic logic [11:0] word_index(input logic [7:0] y, input logic [4:0] xw);
        logic [11:0] yw;
        yw = {4'd0, y};
        return (yw << 4) + (yw << 2) + {7'd0, xw};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_fb_writer.sv
// Palettes PPU pixels, packs 8 shades per word and queues framebuffer writes
// into a double-buffered 160x144 2bpp framebuffer.
module lcd_fb_writer
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_pixel,
    input  logic [1:0]  lcd_color,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic [7:0]  bgp,
    output logic        fb_wr_valid,
    input  logic        fb_wr_ready,
    output logic [12:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        display_bank,
    output logic        frame_done,
    output logic        overflow
);

    logic        r_hs_prev;
    logic        r_vs_prev;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [2:0]  r_group;
    logic [13:0] r_pack;
    logic        r_write_bank;
    logic        r_frame_done;
    logic        r_overflow;

    logic        w_hs_rise;
    logic        w_vs_rise;
    logic        w_accept;
    logic        w_word_done;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [1:0]  w_shade;
    fb_word_t    w_push_word;
    fb_word_t    w_head;
    logic [$bits(fb_word_t)-1:0] w_dout;

    assign w_hs_rise   = lcd_hsync && !r_hs_prev;
    assign w_vs_rise   = lcd_vsync && !r_vs_prev;
    assign w_accept    = lcd_pixel && (r_x < LCD_W) && (r_y < LCD_H) && !w_hs_rise && !w_vs_rise;
    assign w_word_done = w_accept && (r_group == 3'd7);
    assign w_pop       = fb_wr_valid && fb_wr_ready;
    assign w_push      = w_word_done && (!w_full || w_pop);

    always_comb begin
        w_shade = bgp[1:0];
        case (lcd_color)
            2'd0:    w_shade = bgp[1:0];
            2'd1:    w_shade = bgp[3:2];
            2'd2:    w_shade = bgp[5:4];
            default: w_shade = bgp[7:6];
        endcase
    end

    // Only 7 earlier shades are kept; the 8th comes straight from this cycle
    assign w_push_word.addr = {r_write_bank, word_index(r_y, r_x[7:3])};
    assign w_push_word.data = {r_pack, w_shade};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_prev <= 1'b1;
            r_vs_prev <= 1'b1;
        end else begin
            r_hs_prev <= lcd_hsync;
            r_vs_prev <= lcd_vsync;
        end
    end

    // The packer is never cleared: a fresh group overwrites all 14 bits first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_group      <= '0;
            r_pack       <= '0;
            r_write_bank <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_vs_rise;
            if (w_word_done && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_vs_rise) begin
                r_x          <= '0;
                r_y          <= '0;
                r_group      <= '0;
                r_write_bank <= ~r_write_bank;
            end else if (w_hs_rise) begin
                r_x     <= '0;
                r_group <= '0;
                if (r_y < LCD_H) begin
                    r_y <= r_y + 8'd1;
                end
            end else if (w_accept) begin
                r_x     <= r_x + 8'd1;
                r_group <= r_group + 3'd1;
                r_pack  <= {r_pack[11:0], w_shade};
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fb_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_push_word),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head       = w_dout;
    assign fb_wr_valid  = !w_empty;
    assign fb_addr      = w_empty ? '0 : w_head.addr;
    assign fb_data      = w_empty ? '0 : w_head.data;
    assign display_bank = ~r_write_bank;
    assign frame_done   = r_frame_done;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_lcd_fb_writer.sv
// Self-checking bench for lcd_fb_writer against a queue-based reference model.
module tb_lcd_fb_writer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lcd_pixel = 1'b0;
    logic [1:0]  lcd_color = 2'd0;
    logic        lcd_hsync = 1'b0;
    logic        lcd_vsync = 1'b0;
    logic [7:0]  bgp = 8'hE4;
    logic        fb_wr_valid;
    logic        fb_wr_ready = 1'b0;
    logic [12:0] fb_addr;
    logic [15:0] fb_data;
    logic        display_bank;
    logic        frame_done;
    logic        overflow;

    lcd_fb_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_pixel    (lcd_pixel),
        .lcd_color    (lcd_color),
        .lcd_hsync    (lcd_hsync),
        .lcd_vsync    (lcd_vsync),
        .bgp          (bgp),
        .fb_wr_valid  (fb_wr_valid),
        .fb_wr_ready  (fb_wr_ready),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .display_bank (display_bank),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [28:0] m_q[$];
    int          m_sh[$];
    int          m_x, m_y, m_bank;
    bit          m_fd, m_ovf, m_hsp, m_vsp;

    logic [28:0] obs[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_step(input bit pix, input int col, input bit hs, input bit vs,
                                       input bit rdy, input bit rs);
        bit hr, vr, pop, done;
        int data, addr;
        if (rs) begin
            m_q.delete(); m_sh.delete();
            m_x = 0; m_y = 0; m_bank = 0;
            m_fd = 0; m_ovf = 0; m_hsp = 1; m_vsp = 1;
            return;
        end
        hr = hs && !m_hsp;
        vr = vs && !m_vsp;
        m_hsp = hs; m_vsp = vs;
        pop  = (m_q.size() > 0) && rdy;
        done = 0;
        data = 0; addr = 0;
        m_fd = vr;
        if (vr) begin
            m_x = 0; m_y = 0; m_bank = 1 - m_bank; m_sh.delete();
        end else if (hr) begin
            m_x = 0; m_sh.delete();
            if (m_y < 144) m_y++;
        end else if (pix && m_x < 160 && m_y < 144) begin
            m_sh.push_back((int'(bgp) >> (2 * col)) & 3);
            m_x++;
            if (m_sh.size() == 8) begin
                for (int i = 0; i < 8; i++) data += m_sh[i] << (14 - 2 * i);
                addr = m_bank * 4096 + m_y * 20 + (m_x - 1) / 8;
                done = 1;
                m_sh.delete();
            end
        end
        if (pop) void'(m_q.pop_front());
        if (done) begin
            if (m_q.size() < DEPTH) m_q.push_back({13'(addr), 16'(data)});
            else m_ovf = 1;
        end
    endfunction

    task automatic step(input logic pix, input logic [1:0] col, input logic hs, input logic vs,
                        input logic rdy, input logic rs);
        logic [28:0] head;
        @(negedge clk);
        lcd_pixel = pix; lcd_color = col; lcd_hsync = hs; lcd_vsync = vs;
        fb_wr_ready = rdy; rst = rs;
        #1;
        if (!rs && fb_wr_valid === 1'b1 && rdy) obs.push_back({fb_addr, fb_data});
        model_step(pix, int'(col), hs, vs, rdy, rs);
        @(posedge clk);
        #1;
        check_eq("valid", fb_wr_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            head = m_q[0];
            check_eq("addr", fb_addr, head[28:16]);
            check_eq("data", fb_data, head[15:0]);
        end
        check_eq("display_bank", display_bank, m_bank == 0);
        check_eq("frame_done", frame_done, m_fd);
        check_eq("overflow", overflow, m_ovf);
    endtask

    task automatic line_px(input int n, input int cmode, input logic rdy);
        logic [1:0] c;
        for (int i = 0; i < n; i++) begin
            c = (cmode == 0) ? 2'(i % 4) : (cmode == 1) ? 2'd0 : 2'($urandom);
            step(1'b1, c, 1'b0, 1'b0, rdy, 1'b0);
        end
    endtask

    task automatic hblank(input logic rdy);
        step(1'b0, 2'd0, 1'b1, 1'b0, rdy, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_obs(input string tag, input int n, input int base, input int data, input bit chk_data);
        logic [28:0] w;
        check_eq({tag, "_count"}, obs.size(), n);
        for (int i = 0; i < obs.size() && i < n; i++) begin
            w = obs[i];
            check_eq({tag, "_addr"}, w[28:16], base + i);
            if (chk_data) check_eq({tag, "_data"}, w[15:0], data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_addr", fb_addr, 13'd0);
        check_eq("rst_data", fb_data, 16'd0);
        check_eq("rst_bank", display_bank, 1'b1);

        // line 0: palette E4, colors 0..3 repeating
        bgp = 8'hE4; obs.delete();
        line_px(160, 0, 1'b1);
        hblank(1'b1); drain();
        check_obs("line0", 20, 0, 16'h1B1B, 1'b1);

        // line 1: palette 1B, all color 0
        bgp = 8'h1B; obs.delete();
        line_px(160, 1, 1'b1);
        hblank(1'b1); drain();
        check_obs("line1", 20, 20, 16'hFFFF, 1'b1);

        // line 2: backpressure throughout
        bgp = 8'hE4; obs.delete();
        line_px(160, 2, 1'b0);
        check_eq("held_count", obs.size(), 0);
        check_eq("held_valid", fb_wr_valid, 1'b1);
        check_eq("held_addr", fb_addr, 13'd40);
        check_eq("held_ovf", overflow, 1'b1);
        hblank(1'b0); drain();
        check_obs("held", 4, 40, 0, 1'b0);

        // line 3 partial group, then line 4 full
        obs.delete();
        line_px(5, 2, 1'b1);
        hblank(1'b1); drain();
        check_eq("partial_count", obs.size(), 0);
        line_px(160, 2, 1'b1);
        hblank(1'b1); drain();
        check_obs("after_partial", 20, 80, 0, 1'b0);

        // run out the frame, then simultaneous hsync/vsync rise
        for (int i = 0; i < 145; i++) hblank(1'b1);
        step(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("fd_pulse", frame_done, 1'b1);
        check_eq("bank_swap", display_bank, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("fd_once", frame_done, 1'b0);
        obs.delete();
        line_px(16, 2, 1'b1); drain();
        check_obs("bank1", 2, 13'h1000, 0, 1'b0);
        hblank(1'b1);

        // reset with 3 words queued and a partial group
        obs.delete();
        line_px(29, 2, 1'b0);
        check_eq("pre_rst_count", obs.size(), 0);
        step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("post_rst_valid", fb_wr_valid, 1'b0);
        check_eq("post_rst_ovf", overflow, 1'b0);
        check_eq("post_rst_bank", display_bank, 1'b1);
        line_px(16, 2, 1'b1); drain();
        check_obs("post_rst", 2, 0, 0, 1'b0);

        // random lines: random palette, gaps, backpressure, overlong lines, edge-coincident pixels
        for (int l = 0; l < 8; l++) begin
            bgp = 8'($urandom);
            for (int i = 0; i < 150 + int'($urandom_range(0, 20)); i++)
                step(($urandom % 4) != 0, 2'($urandom), 1'b0, 1'b0, 1'($urandom), 1'b0);
            if (l == 4) begin
                step(1'b1, 2'($urandom), 1'b0, 1'b1, 1'($urandom), 1'b0);
                step(1'b0, 2'd0, 1'b0, 1'b0, 1'($urandom), 1'b0);
            end else begin
                step(1'b1, 2'($urandom), 1'b1, 1'b0, 1'($urandom), 1'b0);
                step(1'b0, 2'd0, 1'b0, 1'b0, 1'($urandom), 1'b0);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
